// File: rtl/bsg_cgol_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bsg_cgol_pkg
// Brief    : Shared FSM state type and default sizing for the CGOL controller.
// Revision : 1.0 - initial release
// ============================================================================
package bsg_cgol_pkg;

    localparam int c_DEFAULT_BOARD_WIDTH = 8;
    localparam int c_DEFAULT_GAME_LENGTH = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } cgol_state_e;

endpackage
`default_nettype wire

// File: rtl/bsg_cgol_ctrl_counter.sv
`default_nettype none
// ============================================================================
// Module   : bsg_cgol_ctrl_counter
// Brief    : Loadable generation down-counter; load value saturates at MAX_VAL.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_cgol_ctrl_counter
    import bsg_cgol_pkg::*;
#(
    parameter int MAX_VAL = c_DEFAULT_GAME_LENGTH,
    parameter int WIDTH   = $clog2(MAX_VAL + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_is_one,
    output logic             o_is_zero
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= (i_load_val > c_MAX) ? c_MAX : i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_is_one  = (r_cnt == WIDTH'(1));
    assign o_is_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/bsg_cgol_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bsg_cgol_ctrl
// Brief    : Job controller for a Game-of-Life cell array: loads the board,
//            issues one step enable per generation, returns the final board.
//            Optional still-life early exit: BSG_CGOL_CTRL_EARLY_EXIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_cgol_ctrl
    import bsg_cgol_pkg::*;
#(
    parameter int board_width_p     = c_DEFAULT_BOARD_WIDTH,
    parameter int max_game_length_p = c_DEFAULT_GAME_LENGTH,
    localparam int c_N  = board_width_p * board_width_p,
    localparam int c_FW = $clog2(max_game_length_p + 1)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            v_i,
    output logic            ready_o,
    input  logic [c_N-1:0]  data_i,
    input  logic [c_FW-1:0] frames_i,
    output logic            en_o,
    output logic            update_o,
    output logic [c_N-1:0]  update_val_o,
    input  logic [c_N-1:0]  board_i,
    output logic            v_o,
    output logic [c_N-1:0]  data_o,
    input  logic            yumi_i
);

    cgol_state_e    r_state;
    cgol_state_e    w_next_state;
    logic [c_N-1:0] r_board;
    logic           w_capture;
    logic           w_dec;
    logic           w_cnt_one;
    logic           w_cnt_zero;

    bsg_cgol_ctrl_counter #(
        .MAX_VAL (max_game_length_p),
        .WIDTH   (c_FW)
    ) u_counter (
        .clk        (clk_i),
        .rst        (reset_i),
        .i_load     (w_capture),
        .i_load_val (frames_i),
        .i_dec      (w_dec),
        .o_is_one   (w_cnt_one),
        .o_is_zero  (w_cnt_zero)
    );

`ifdef BSG_CGOL_CTRL_EARLY_EXIT_EN
    logic [c_N-1:0] r_prev;
    logic           r_run_first;

    // The first RUN cycle has no valid previous board to compare against.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_prev      <= '0;
            r_run_first <= 1'b0;
        end else if (r_state == LOAD) begin
            r_run_first <= 1'b1;
        end else if (r_state == RUN) begin
            r_prev      <= board_i;
            r_run_first <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_board <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_board <= data_i;
            end
        end
    end

    // All outputs are held low while reset is asserted, whatever the state.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_dec        = 1'b0;
        ready_o      = 1'b0;
        en_o         = 1'b0;
        update_o     = 1'b0;
        update_val_o = '0;
        v_o          = 1'b0;
        data_o       = '0;
        if (!reset_i) begin
            case (r_state)
                IDLE: begin
                    ready_o = 1'b1;
                    if (v_i) begin
                        w_capture    = 1'b1;
                        w_next_state = LOAD;
                    end
                end
                LOAD: begin
                    update_o     = 1'b1;
                    update_val_o = r_board;
                    w_next_state = w_cnt_zero ? DONE : RUN;
                end
                RUN: begin
`ifdef BSG_CGOL_CTRL_EARLY_EXIT_EN
                    if (!r_run_first && (board_i == r_prev)) begin
                        w_next_state = DONE;
                    end else begin
                        en_o  = 1'b1;
                        w_dec = 1'b1;
                        if (w_cnt_one) begin
                            w_next_state = DONE;
                        end
                    end
`else
                    en_o  = 1'b1;
                    w_dec = 1'b1;
                    if (w_cnt_one) begin
                        w_next_state = DONE;
                    end
`endif
                end
                DONE: begin
                    v_o    = 1'b1;
                    data_o = board_i;
                    if (yumi_i) begin
                        w_next_state = IDLE;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bsg_cgol_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_cgol_ctrl
// Brief    : Self-checking bench for bsg_cgol_ctrl with a behavioural 8x8 array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_cgol_ctrl;

    localparam int W    = 8;
    localparam int N    = W * W;
    localparam int MAXG = 1024;
    localparam int FW   = $clog2(MAXG + 1);

    logic          clk = 1'b0;
    logic          reset_i;
    logic          v_i;
    logic          ready_o;
    logic [N-1:0]  data_i;
    logic [FW-1:0] frames_i;
    logic          en_o;
    logic          update_o;
    logic [N-1:0]  update_val_o;
    logic [N-1:0]  board_i = '0;
    logic          v_o;
    logic [N-1:0]  data_o;
    logic          yumi_i;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    bsg_cgol_ctrl #(
        .board_width_p     (W),
        .max_game_length_p (MAXG)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .v_i          (v_i),
        .ready_o      (ready_o),
        .data_i       (data_i),
        .frames_i     (frames_i),
        .en_o         (en_o),
        .update_o     (update_o),
        .update_val_o (update_val_o),
        .board_i      (board_i),
        .v_o          (v_o),
        .data_o       (data_o),
        .yumi_i       (yumi_i)
    );

    // One Game-of-Life generation; cells beyond the edge are dead.
    function automatic logic [N-1:0] life(input logic [N-1:0] b);
        logic [N-1:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < W; r++) begin
            for (int c = 0; c < W; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < W &&
                            c + dc >= 0 && c + dc < W)
                            cnt += int'(b[(r + dr) * W + c + dc]);
                n[r * W + c] = (cnt == 3) || (b[r * W + c] && cnt == 2);
            end
        end
        return n;
    endfunction

    // Behavioural cell array driven by the controller's broadcasts.
    always @(posedge clk) begin
        if (update_o)  board_i <= update_val_o;
        else if (en_o) board_i <= life(board_i);
    end

    // Expected final board, step count and acceptance-to-v_o latency.
    task automatic predict(input logic [N-1:0] b0, input int frames,
                           output logic [N-1:0] res, output int pulses, output int lat);
        logic [N-1:0] cur, nxt;
        int f;
        f = (frames > MAXG) ? MAXG : frames;
        cur = b0;
        pulses = 0;
        lat = f + 2;
        for (int k = 0; k < f; k++) begin
            nxt = life(cur);
            pulses++;
`ifdef BSG_CGOL_CTRL_EARLY_EXIT_EN
            if (nxt == cur && k + 1 < f) begin
                res = nxt;
                lat = pulses + 3;
                return;
            end
`endif
            cur = nxt;
        end
        res = cur;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_job(input string tag, input logic [N-1:0] b, input logic [FW-1:0] fr,
                           input int hold, output int obs_pulses, output int obs_lat,
                           output logic [N-1:0] obs_data);
        logic [N-1:0] exp_res;
        int exp_p, exp_lat, cyc;
        bit bad, done;
        predict(b, int'(fr), exp_res, exp_p, exp_lat);
        cyc = 0;
        while (!ready_o && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " ready"}, 64'(ready_o), 64'd1);
        v_i = 1'b1; data_i = b; frames_i = fr;
        @(negedge clk);
        v_i = 1'b0;
        obs_pulses = 0; bad = 1'b0; done = 1'b0; cyc = 1;
        check({tag, " load"}, {update_val_o[N-2:0], update_o}, {b[N-2:0], 1'b1});
        while (cyc < exp_lat + 20) begin
            if (v_o) begin
                done = 1'b1;
                break;
            end
            if (en_o) obs_pulses++;
            if ((en_o && update_o) || (cyc > 1 && (update_o || update_val_o != '0))) bad = 1'b1;
            if (ready_o) bad = 1'b1;
            v_i = 1'($urandom); data_i = {$urandom, $urandom}; frames_i = FW'($urandom);
            @(negedge clk);
            cyc++;
        end
        v_i = 1'b0;
        obs_lat = cyc;
        obs_data = data_o;
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " strobes"}, 64'(bad), 64'd0);
        check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, " pulses"}, 64'(obs_pulses), 64'(exp_p));
        check({tag, " data_o"}, data_o, exp_res);
        for (int h = 0; h < hold; h++) begin
            v_i = 1'($urandom); data_i = {$urandom, $urandom};
            @(negedge clk);
            check({tag, " hold"}, {60'(data_o == exp_res), en_o, ready_o, v_o}, {60'd1, 3'b001});
        end
        yumi_i = 1'b1; v_i = 1'b0;
        @(negedge clk);
        yumi_i = 1'b0;
        check({tag, " idle"}, {62'd0, ready_o, v_o}, {62'd0, 2'b10});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] blinker, blinker_h, block, rb, od;
        int p, l;
        blinker   = '0; blinker[28] = 1'b1; blinker[36] = 1'b1; blinker[44] = 1'b1;
        blinker_h = '0; blinker_h[35] = 1'b1; blinker_h[36] = 1'b1; blinker_h[37] = 1'b1;
        block     = '0; block[18] = 1'b1; block[19] = 1'b1; block[26] = 1'b1; block[27] = 1'b1;

        reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; data_i = '0; frames_i = '0;
        repeat (2) @(negedge clk);
        v_i = 1'b1;
        #1;
        check("reset outputs", {59'd0, ready_o, v_o, en_o, update_o, 1'b0} | 64'(update_val_o != '0)
              | 64'(data_o != '0), 64'd0);
        @(negedge clk);
        v_i = 1'b0; reset_i = 1'b0;
        #1;
        check("post-reset ready", {62'd0, ready_o, v_o}, {62'd0, 2'b10});

        run_job("blinker", blinker, FW'(1), 0, p, l, od);
        check("blinker pulses", 64'(p), 64'd1);
        check("blinker latency", 64'(l), 64'd3);
        check("blinker board", od, blinker_h);

        rb = {$urandom, $urandom};
        run_job("zero", rb, FW'(0), 1, p, l, od);
        check("zero pulses", 64'(p), 64'd0);
        check("zero latency", 64'(l), 64'd2);
        check("zero board", od, rb);

        run_job("block", block, FW'(5), 0, p, l, od);
`ifdef BSG_CGOL_CTRL_EARLY_EXIT_EN
        check("block pulses", 64'(p), 64'd1);
`else
        check("block pulses", 64'(p), 64'd5);
`endif
        check("block board", od, block);

        run_job("backpressure", blinker, FW'(2), 10, p, l, od);
        check("backpressure board", od, blinker);

        // Reset pulse in the middle of a long run.
        @(negedge clk);
        v_i = 1'b1; data_i = {$urandom, $urandom}; frames_i = FW'(100);
        @(negedge clk);
        v_i = 1'b0;
        repeat (5) @(negedge clk);
        reset_i = 1'b1;
        #1;
        check("midrun reset outputs", {61'd0, ready_o, v_o, en_o}, 64'd0);
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        check("midrun after reset", {61'd0, en_o, v_o, ready_o}, {61'd0, 3'b001});
        run_job("after reset", blinker, FW'(1), 0, p, l, od);
        check("after reset board", od, blinker_h);

        for (int i = 0; i < 6; i++) begin
            rb = {$urandom, $urandom} & {$urandom, $urandom};
            run_job("random", rb, FW'($urandom_range(0, 8)), int'($urandom_range(0, 3)), p, l, od);
        end

        rb = {$urandom, $urandom};
        run_job("saturate", rb, FW'(2047), 0, p, l, od);
`ifndef BSG_CGOL_CTRL_EARLY_EXIT_EN
        check("saturate pulses", 64'(p), 64'd1024);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bsg_cgol_ctrl.md
BSG_CGOL_CTRL -- requirements
Module: bsg_cgol_ctrl

Interface
REQ-001 Parameter board_width_p, default 8: board is board_width_p x board_width_p cells; flat vectors are N = board_width_p^2 bits, bit (r*board_width_p+c) = row r, column c.
REQ-002 Parameter max_game_length_p, default 1024: largest accepted generation count; counter width FW = $clog2(max_game_length_p+1).
REQ-003 Clock and reset: one clock, clk_i; reset_i is synchronous and active-high.
REQ-004 Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- v_i  in  1  job valid
- ready_o  out  1  controller accepts job
- data_i  in  N  initial board
- frames_i  in  FW  generations to simulate
- en_o  out  1  step enable broadcast to every cell
- update_o  out  1  load strobe broadcast to every cell
- update_val_o  out  N  per-cell load values
- board_i  in  N  current cell states from the array
- v_o  out  1  result valid
- data_o  out  N  final board
- yumi_i  in  1  consumer takes result; legal only while v_o=1

Function
REQ-005 FSM states: IDLE, LOAD, RUN, DONE.
REQ-006 IDLE: ready_o=1. v_i & ready_o captures data_i into board_r and frames_i into cnt_r; next state is LOAD.
REQ-007 LOAD: lasts exactly one cycle; update_o=1; update_val_o=board_r; en_o=0. Next state is RUN if cnt_r!=0, else DONE.
REQ-008 RUN: en_o=1 every cycle; cnt_r decrements each cycle. Transition to DONE on the cycle cnt_r==1, so exactly frames_i en_o pulses are issued.
REQ-009 DONE: v_o=1; data_o=board_i. Outputs hold while yumi_i=0. yumi_i=1 returns the FSM to IDLE on the next cycle.
REQ-010 en_o and update_o are never asserted in the same cycle.
REQ-011 update_val_o is 0 outside LOAD.
REQ-012 ready_o is 0 in LOAD, RUN and DONE; v_i there is ignored, with no capture.
REQ-013 Latency from acceptance to v_o: frames_i+2 cycles, minimum 2 cycles when frames_i=0.
REQ-014 frames_i > max_game_length_p is saturated to max_game_length_p at capture.
REQ-015 Back-to-back jobs: the earliest the next acceptance can occur is the cycle after the yumi_i cycle.

Reset
REQ-016 reset_i=1 at a clock edge forces IDLE, sets cnt_r=0 and board_r=0. This applies in any state, including mid-RUN and mid-DONE.
REQ-017 Outputs while reset_i is high: ready_o=0, v_o=0, en_o=0, update_o=0, update_val_o=0, data_o=0.
REQ-018 After reset: ready_o=1 on the first cycle with reset_i=0.

Configuration
REQ-019 Macro BSG_CGOL_CTRL_EARLY_EXIT_EN defined:
- Every RUN cycle registers board_i into prev_r.
- On any RUN cycle after the first, if board_i==prev_r (still life), en_o=0 that cycle and the next state is DONE regardless of cnt_r.
REQ-020 Macro undefined: no prev_r exists; RUN always issues exactly frames_i pulses.

Structure
REQ-021 Shared package bsg_cgol_pkg holds:
- the FSM state enum (IDLE, LOAD, RUN, DONE), 2 bits
- default board width constant
- default game-length constant
REQ-022 Sub-module: bsg_cgol_ctrl_counter, a loadable down-counter with saturation on load and a ==1 / ==0 flag.
REQ-023 The block contains no cell logic; the cell array is instantiated beside it by the parent.

Verification
REQ-024 The bench connects a behavioural 8x8 cell array, so that board_i follows en_o and update_o.
REQ-025 Blinker: vertical cells (3,4),(4,4),(5,4) with frames_i=1. Required response:
- LOAD then one en_o pulse
- v_o at cycle 3 after acceptance
- data_o shows horizontal cells (4,3),(4,4),(4,5)
REQ-026 Zero frames: random board with frames_i=0. Required response: no en_o pulse; v_o 2 cycles after acceptance; data_o equals data_i.
REQ-027 Still life: 2x2 block at (2,2) with frames_i=5. Required response:
- Macro undefined: 5 en_o pulses, data_o equals the block.
- Macro defined: 1 en_o pulse, then DONE; data_o equals the block.
REQ-028 Back-pressure and ignored input:
- Stimulus: yumi_i held 0 for 10 cycles in DONE; v_i toggled throughout.
- Response: v_o and data_o stable; ready_o=0; no capture.
- Then yumi_i=1: IDLE and ready_o=1 next cycle.
REQ-029 Reset mid-run: reset_i=1 for 1 cycle during RUN of a frames_i=100 job. Required response:
- next cycle en_o=0, v_o=0
- ready_o=1 once reset_i=0
- a new job then completes normally
REQ-030 Saturation: frames_i=2047 with max_game_length_p=1024. Required response: exactly 1024 en_o pulses with the macro undefined.
